// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module      : rr_mux_arbiter
// Description : Round-robin arbiter for a shared 8:1 single-bit mux with a
//               registered select and data output. Optional forced release
//               after MAX_HOLD grant cycles when MUX_HOLD_LIMIT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       out,
  output logic       out_valid,
  output logic       busy
);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_GRANT = 1'b1;

  logic [0:0] r_state, w_state_n;
  logic [7:0] r_gnt, w_gnt_n;
  logic [2:0] r_sel, w_sel_n;
  logic [2:0] r_last, w_last_n;
  logic       r_out, w_out_n;
  logic       r_out_valid, w_ov_n;
  logic [2:0] w_win;
  logic       w_found;
  logic       w_do_arb;
  logic       w_release;
  logic       w_force;

`ifdef MUX_HOLD_LIMIT_EN
  localparam int c_HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [c_HW-1:0] c_HOLD_MAX = c_HW'(MAX_HOLD - 1);

  logic [c_HW-1:0] r_hold_cnt, w_hold_n;

  // Force release only when someone else is waiting; otherwise the count restarts.
  assign w_force = (r_hold_cnt == c_HOLD_MAX) && (|(req & ~r_gnt));
`else
  assign w_force = 1'b0;
`endif

  assign w_release = ~req[r_sel];

  // Rotating priority search starting just after the last winner.
  always_comb begin
    w_win   = r_last;
    w_found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!w_found && req[r_last + 3'(i)]) begin
        w_win   = r_last + 3'(i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= c_ST_IDLE;
      r_gnt       <= 8'h00;
      r_sel       <= 3'd0;
      r_last      <= 3'd7;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef MUX_HOLD_LIMIT_EN
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_gnt       <= w_gnt_n;
      r_sel       <= w_sel_n;
      r_last      <= w_last_n;
      r_out       <= w_out_n;
      r_out_valid <= w_ov_n;
`ifdef MUX_HOLD_LIMIT_EN
      r_hold_cnt  <= w_hold_n;
`endif
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_gnt_n   = r_gnt;
    w_sel_n   = r_sel;
    w_last_n  = r_last;
    w_out_n   = r_out;
    w_ov_n    = r_out_valid;
    w_do_arb  = 1'b0;
`ifdef MUX_HOLD_LIMIT_EN
    w_hold_n  = r_hold_cnt;
`endif
    case (r_state)
      c_ST_IDLE: begin
        if (|req) w_do_arb = 1'b1;
      end
      c_ST_GRANT: begin
        if (w_release || w_force) begin
          if (|req) begin
            // Handover on the same edge keeps out_valid high with no bubble.
            w_do_arb = 1'b1;
            w_out_n  = d[r_sel];
            w_ov_n   = 1'b1;
          end else begin
            w_state_n = c_ST_IDLE;
            w_gnt_n   = 8'h00;
            w_ov_n    = 1'b0;
          end
        end else begin
          w_out_n = d[r_sel];
          w_ov_n  = 1'b1;
`ifdef MUX_HOLD_LIMIT_EN
          w_hold_n = (r_hold_cnt == c_HOLD_MAX) ? '0 : r_hold_cnt + 1'b1;
`endif
        end
      end
      default: w_state_n = c_ST_IDLE;
    endcase

    if (w_do_arb) begin
      w_state_n = c_ST_GRANT;
      w_gnt_n   = 8'(1) << w_win;
      w_sel_n   = w_win;
      w_last_n  = w_win;
`ifdef MUX_HOLD_LIMIT_EN
      w_hold_n  = '0;
`endif
    end
  end

  always_comb begin
    gnt       = r_gnt;
    sel       = r_sel;
    out       = r_out;
    out_valid = r_out_valid;
    busy      = (r_state == c_ST_GRANT);
  end

endmodule

`default_nettype wire
